// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a univ_shift_reg datapath: accepts one command over valid/ready,
// drives an optional parallel load followed by a counted run of shifts, then pulses done.
module shift_seq_ctrl #(
   parameter int N  = 4,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_load,
   input  logic [N-1:0]  cmd_data,
   input  logic          cmd_dir,
   input  logic [AW-1:0] cmd_amt,
   input  logic          cmd_fill,
   output logic [1:0]    sr_ctrl,
   output logic [N-1:0]  sr_d,
   output logic          busy,
   output logic          done
);

   // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
   // cmd_ready is high only in IDLE (and low while rst is held), so cmd_* is ignored elsewhere.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CTRL_HOLD  = 2'b00;
   localparam logic [1:0] CTRL_RIGHT = 2'b01;
   localparam logic [1:0] CTRL_LEFT  = 2'b10;
   localparam logic [1:0] CTRL_LOAD  = 2'b11;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  data_q, data_d;
   logic          dir_q, dir_d;
   logic          fill_q, fill_d;
   logic          accept;

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d  = cmd_amt;
               data_d = cmd_data;
               dir_d  = cmd_dir;
               fill_d = cmd_fill;
               if (cmd_load)
                  state_d = LOAD;
               else if (cmd_amt != '0)
                  state_d = SHIFT;
               else
                  state_d = DONE;
            end
         end
         LOAD: begin
            state_d = (cnt_q != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            // The counter holds the shifts still to issue, this cycle included.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == AW'(1))
               state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      sr_ctrl = CTRL_HOLD;
      sr_d    = '0;
      busy    = (state_q != IDLE);
      done    = 1'b0;
      case (state_q)
         LOAD: begin
            sr_ctrl = CTRL_LOAD;
            sr_d    = data_q;
         end
         SHIFT: begin
            sr_ctrl = dir_q ? CTRL_LEFT : CTRL_RIGHT;
            sr_d    = {N{fill_q}};
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            sr_ctrl = CTRL_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural univ_shift_reg driven by the DUT outputs.
module tb_shift_seq_ctrl;

   localparam int N  = 4;
   localparam int AW = 3;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_load;
   logic [N-1:0]  cmd_data;
   logic          cmd_dir;
   logic [AW-1:0] cmd_amt;
   logic          cmd_fill;
   logic [1:0]    sr_ctrl;
   logic [N-1:0]  sr_d;
   logic          busy;
   logic          done;

   int checks = 0;
   int fails  = 0;

   logic [N-1:0] q_model = '0;
   logic [1:0]   trace [0:15];
   int           lat;
   logic         done_busy;
   logic         done_ready;
   logic [N-1:0] done_q;

   shift_seq_ctrl #(.N(N), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_load  (cmd_load),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_amt   (cmd_amt),
      .cmd_fill  (cmd_fill),
      .sr_ctrl   (sr_ctrl),
      .sr_d      (sr_d),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Right shift takes its serial input from d[N-1], left shift from d[0].
   always @(posedge clk) begin
      case (sr_ctrl)
         2'b01:   q_model <= {sr_d[N-1], q_model[N-1:1]};
         2'b10:   q_model <= {q_model[N-2:0], sr_d[0]};
         2'b11:   q_model <= sr_d;
         default: q_model <= q_model;
      endcase
   end

   // Called in an IDLE cycle (#1 after an edge); returns in the IDLE cycle after done.
   task automatic issue(input logic ld, input logic [N-1:0] dat, input logic dr,
                        input logic [AW-1:0] am, input logic fl);
      cmd_load  = ld;
      cmd_data  = dat;
      cmd_dir   = dr;
      cmd_amt   = am;
      cmd_fill  = fl;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      done_busy = 1'b0;
      done_ready = 1'b1;
      done_q = 'x;
      for (int i = 0; i < 16; i++) trace[i] = 2'b00;
      for (int k = 1; k <= 15; k++) begin
         trace[k] = sr_ctrl;
         if (done === 1'b1) begin
            lat = k;
            done_busy = busy;
            done_ready = cmd_ready;
            done_q = q_model;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_load = 1'b0;
      cmd_data = '0;
      cmd_dir = 1'b0;
      cmd_amt = '0;
      cmd_fill = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
      checks++;
      if (sr_ctrl !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || sr_d !== 4'h0) begin
         fails++; $display("FAIL reset_outs got ctrl=%b d=%h busy=%b done=%b exp 00/0/0/0", sr_ctrl, sr_d, busy, done);
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (sr_ctrl !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL idle_outs c=%0d got ctrl=%b busy=%b done=%b ready=%b exp 00/0/0/1", c, sr_ctrl, busy, done, cmd_ready);
         end
      end
   endtask

   task automatic test_load_right();
      issue(1'b1, 4'h6, 1'b0, 3'd2, 1'b0);
      checks++;
      if (trace[1] !== 2'b11 || trace[2] !== 2'b01 || trace[3] !== 2'b01) begin
         fails++; $display("FAIL load_right_ctrl got %b %b %b exp 11 01 01", trace[1], trace[2], trace[3]);
      end
      checks++;
      if (lat !== 4) begin fails++; $display("FAIL load_right_lat got=%0d exp=4", lat); end
      checks++;
      if (done_q !== 4'h1) begin fails++; $display("FAIL load_right_q got=%h exp=1", done_q); end
      checks++;
      if (done_busy !== 1'b1 || done_ready !== 1'b0) begin
         fails++; $display("FAIL done_flags got busy=%b ready=%b exp 1/0", done_busy, done_ready);
      end
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++; $display("FAIL post_done_idle got busy=%b ready=%b exp 0/1", busy, cmd_ready);
      end
   endtask

   task automatic test_shift_left();
      issue(1'b1, 4'h6, 1'b0, 3'd0, 1'b0);
      checks++;
      if (lat !== 2 || done_q !== 4'h6 || trace[1] !== 2'b11) begin
         fails++; $display("FAIL preload got lat=%0d q=%h ctrl=%b exp 2/6/11", lat, done_q, trace[1]);
      end
      issue(1'b0, 4'h0, 1'b1, 3'd1, 1'b1);
      checks++;
      if (trace[1] !== 2'b10) begin fails++; $display("FAIL left_ctrl got=%b exp=10", trace[1]); end
      checks++;
      if (lat !== 2) begin fails++; $display("FAIL left_lat got=%0d exp=2", lat); end
      checks++;
      if (done_q !== 4'hD) begin fails++; $display("FAIL left_q got=%h exp=d", done_q); end
   endtask

   task automatic test_zero_amt();
      issue(1'b0, 4'hA, 1'b0, 3'd0, 1'b1);
      checks++;
      if (lat !== 1 || trace[1] !== 2'b00) begin
         fails++; $display("FAIL zero_nop got lat=%0d ctrl=%b exp 1/00", lat, trace[1]);
      end
      checks++;
      if (done_q !== 4'hD) begin fails++; $display("FAIL zero_nop_q got=%h exp=d", done_q); end
      issue(1'b1, 4'h9, 1'b0, 3'd0, 1'b0);
      checks++;
      if (lat !== 2 || trace[1] !== 2'b11) begin
         fails++; $display("FAIL zero_load got lat=%0d ctrl=%b exp 2/11", lat, trace[1]);
      end
      checks++;
      if (done_q !== 4'h9) begin fails++; $display("FAIL zero_load_q got=%h exp=9", done_q); end
   endtask

   task automatic test_long_amt();
      issue(1'b0, 4'h0, 1'b1, 3'd6, 1'b1);
      checks++;
      if (lat !== 7) begin fails++; $display("FAIL long_lat got=%0d exp=7", lat); end
      checks++;
      if (done_q !== 4'hF) begin fails++; $display("FAIL long_q got=%h exp=f", done_q); end
   endtask

   task automatic test_back_to_back();
      int k;
      cmd_load = 1'b1; cmd_data = 4'h9; cmd_dir = 1'b1; cmd_amt = 3'd3; cmd_fill = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      // Second command queued immediately; valid stays high.
      cmd_load = 1'b0; cmd_data = 4'h0; cmd_dir = 1'b0; cmd_amt = 3'd1; cmd_fill = 1'b1;
      k = 1;
      while (done !== 1'b1 && k < 15) begin
         checks++;
         if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready c=%0d got=%b exp=0", k, cmd_ready); end
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k !== 5 || done !== 1'b1) begin fails++; $display("FAIL b2b_lat got=%0d exp=5", k); end
      checks++;
      if (q_model !== 4'h8 || cmd_ready !== 1'b0) begin
         fails++; $display("FAIL b2b_q got q=%h ready=%b exp 8/0", q_model, cmd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL b2b_idle got ready=%b busy=%b exp 1/0", cmd_ready, busy);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || sr_ctrl !== 2'b01) begin
         fails++; $display("FAIL b2b_second got busy=%b ctrl=%b exp 1/01", busy, sr_ctrl);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || q_model !== 4'hC) begin
         fails++; $display("FAIL b2b_second_done got done=%b q=%h exp 1/c", done, q_model);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift();
      cmd_load = 1'b0; cmd_data = 4'h0; cmd_dir = 1'b0; cmd_amt = 3'd7; cmd_fill = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (sr_ctrl !== 2'b01 || busy !== 1'b1) begin
         fails++; $display("FAIL mid_shift got ctrl=%b busy=%b exp 01/1", sr_ctrl, busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sr_ctrl !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
         fails++; $display("FAIL mid_reset got ctrl=%b busy=%b done=%b ready=%b exp 00/0/0/0", sr_ctrl, busy, done, cmd_ready);
      end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || sr_ctrl !== 2'b00) begin
            fails++; $display("FAIL post_reset c=%0d got done=%b busy=%b ready=%b ctrl=%b exp 0/0/1/00", c, done, busy, cmd_ready, sr_ctrl);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_right();
      test_shift_left();
      test_zero_amt();
      test_long_amt();
      test_back_to_back();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer for a univ_shift_reg datapath (ctrl encoding 00 hold, 01 right shift, 10 left shift, 11 parallel load). It accepts one command at a time over a valid/ready handshake. Each command is an optional parallel load followed by a programmable number of shifts in one direction, with a selectable fill bit. The block drives the shift register's ctrl and d inputs cycle by cycle and pulses done once the register holds the final value.

Parameters:
N, 4, data width of the controlled shift register (sr_d width).
AW, 3, width of the shift-amount field; max shift count per command = 2^AW-1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command this cycle.
cmd_load  input  1  1 = parallel-load cmd_data before shifting.
cmd_data  input  N  load value (used only when cmd_load=1).
cmd_dir  input  1  0 = right shift (ctrl 01), 1 = left shift (ctrl 10).
cmd_amt  input  AW  number of shift cycles (0 allowed).
cmd_fill  input  1  bit shifted into the vacated position.
sr_ctrl  output  2  ctrl to univ_shift_reg.
sr_d  output  N  d to univ_shift_reg.
busy  output  1  command in progress (state != IDLE).
done  output  1  single-cycle pulse: command complete, register holds final value.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, counter=0, latched fields cleared. While rst=1 and in the cycle after reset: sr_ctrl=00, sr_d=0, busy=0, done=0. cmd_ready=0 while rst=1 and 1 from the first cycle after rst deasserts.
- States: IDLE, LOAD, SHIFT, DONE. All outputs decode from registered state and latched fields only; no combinational path from cmd_* to sr_*.
- IDLE: cmd_ready=1, sr_ctrl=00, sr_d=0. Acceptance = cmd_valid & cmd_ready at a rising edge; latch load/data/dir/amt/fill and set counter=cmd_amt.
  - Next state on acceptance: cmd_load=1 -> LOAD; else if cmd_amt!=0 -> SHIFT; else -> DONE.
  - No acceptance -> stay in IDLE.
- LOAD (exactly 1 cycle): sr_ctrl=11, sr_d=latched data. Next: SHIFT if counter!=0, else DONE.
- SHIFT: sr_ctrl=01 (dir=0) or 10 (dir=1); sr_d={N{fill}}, so the fill bit enters whichever end the register samples. Counter decrements each cycle; leave to DONE when counter==1. Exactly amt SHIFT cycles.
- DONE (exactly 1 cycle): sr_ctrl=00, sr_d=0, done=1, busy=1, cmd_ready=0. Next: IDLE.
- Latency from the acceptance edge to the done cycle: (load?1:0) + amt + 1 cycles. Next command is accepted no earlier than the first IDLE cycle after DONE (back-to-back period = latency + 1).
- cmd_ready=0 in LOAD/SHIFT/DONE; cmd_* changes there are ignored.
- amt=0 with load=0: no datapath activity (ctrl stays 00), DONE still pulses once.
- amt above N is legal; the controller shifts the full count, so the register ends filled with the fill bit.
- Reset mid-command (any state): next cycle is IDLE with sr_ctrl=00; the shift register is not restored; no done pulse.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, cmd_valid=0 for 5 cycles -> sr_ctrl=00, busy=0, done=0, cmd_ready=1 after reset.
- Load+right: cmd{load=1, data=4'h6, dir=0, amt=2, fill=0} -> sr_ctrl 11, 01, 01, then done in the 4th cycle after acceptance; q=4'h1.
- Shift only, left fill 1: q=4'h6 preloaded, cmd{load=0, dir=1, amt=1, fill=1} -> one 10 cycle, done 2 cycles after acceptance; q=4'hD.
- Zero amount: cmd{load=0, amt=0} -> no nonzero sr_ctrl, done 1 cycle after acceptance, q unchanged; cmd{load=1, data=4'h9, amt=0} -> q=4'h9, done 2 cycles after acceptance.
- Back-to-back with cmd_valid held high: cmd{load=1, data=4'h9, dir=1, amt=3, fill=0} -> q=4'h8, cmd_ready=0 from acceptance until the IDLE cycle after done; a second queued command is accepted exactly in that IDLE cycle.
- Reset mid-SHIFT: cmd amt=7, assert rst in the 3rd SHIFT cycle -> next cycle sr_ctrl=00, busy=0, no done pulse, cmd_ready=1 after rst drops.
